// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs micro-op requests into 32-bit instruction words
// and streams them into instruction memory one word every two cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | after reset, waiting for start_i
// S_ACCEPT | op_ready_o high, waiting for a request
// S_WRITE  | presenting the latched word on the memory write port
// S_DONE   | session ended on a last_i op; flags held until start_i
// S_ERROR  | session aborted (illegal kind or overflow); flags held

module instr_encoder_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int ADDR_W     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [2:0]        op_kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic              last_i,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   word_ptr;
    logic                last_q;
    logic [31:0]         word_enc;
    logic                kind_legal;
    logic                accept;
    logic                restart;
    logic                ptr_at_end;

    assign accept     = op_valid_i & op_ready_o;
    assign ptr_at_end = (word_ptr == ADDR_W'(IMEM_WORDS - 1));

    // Encode the request fields using the decoder's opcode map.
    always_comb begin
        kind_legal = 1'b1;
        word_enc   = '0;
        case (op_kind_i)
            3'd0:    word_enc = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            3'd1:    word_enc = {6'b001001, rs_i, rt_i, imm_i};
            3'd2:    word_enc = {6'b101100, rs_i, rt_i, imm_i};
            3'd3:    word_enc = {6'b100100, rs_i, rt_i, imm_i};
            3'd4:    word_enc = {6'b000110, rs_i, rt_i, imm_i};
            3'd5:    word_enc = {6'b000101, rs_i, rt_i, imm_i};
            default: kind_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_nxt  = state;
        op_ready_o = 1'b0;
        imem_we_o  = 1'b0;
        restart    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    restart   = 1'b1;
                    state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    state_nxt = kind_legal ? S_WRITE : S_ERROR;
                end
            end
            S_WRITE: begin
                // Gated by reset so a reset landing on the write edge commits nothing.
                imem_we_o = rst_i;
                if (last_q) begin
                    state_nxt = S_DONE;
                end else if (ptr_at_end) begin
                    state_nxt = S_ERROR;
                end else begin
                    state_nxt = S_ACCEPT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latched word/address, pointer, counter and sticky status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            word_ptr     <= '0;
            count_o      <= '0;
            last_q       <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= 2'b00;
        end else begin
            if (restart) begin
                word_ptr   <= '0;
                count_o    <= '0;
                done_o     <= 1'b0;
                err_o      <= 1'b0;
                err_code_o <= 2'b00;
            end
            if (accept) begin
                if (kind_legal) begin
                    imem_addr_o  <= {{(30 - ADDR_W){1'b0}}, word_ptr, 2'b00};
                    imem_wdata_o <= word_enc;
                    last_q       <= last_i;
                end else begin
                    err_o      <= 1'b1;
                    err_code_o <= 2'b01;
                end
            end
            if (state == S_WRITE) begin
                word_ptr <= ptr_at_end ? '0 : word_ptr + 1'b1;
                count_o  <= count_o + 1'b1;
                if (last_q) begin
                    done_o <= 1'b1;
                end else if (ptr_at_end) begin
                    err_o      <= 1'b1;
                    err_code_o <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: a default-size instance and a 4-word
// instance share the request bus; expected writes go into per-instance queues
// that negedge monitors drain and compare.

module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        valid, last;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic        ready_a, we_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [7:0]  count_a;
    logic [1:0]  code_a;

    logic        ready_b, we_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [2:0]  count_b;
    logic [1:0]  code_b;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t ea, eb;

    int checks   = 0;
    int failures = 0;
    bit acc;

    always #5 clk = ~clk;

    instr_encoder_loader dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .op_valid_i(valid),
        .op_ready_o(ready_a), .op_kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .funct_i(funct), .imm_i(imm), .last_i(last), .imem_we_o(we_a),
        .imem_addr_o(addr_a), .imem_wdata_o(wdata_a), .count_o(count_a),
        .done_o(done_a), .err_o(err_a), .err_code_o(code_a)
    );

    instr_encoder_loader #(.IMEM_WORDS(4), .ADDR_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .op_valid_i(valid),
        .op_ready_o(ready_b), .op_kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .funct_i(funct), .imm_i(imm), .last_i(last), .imem_we_o(we_b),
        .imem_addr_o(addr_b), .imem_wdata_o(wdata_b), .count_o(count_b),
        .done_o(done_b), .err_o(err_b), .err_code_o(code_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor for the default instance's write port.
    always @(negedge clk) begin
        if (we_a) begin
            check("ready_low_in_write_a", 32'(ready_a), 0);
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write_a actual addr=0x%0h data=0x%0h required=no write", addr_a, wdata_a);
            end else begin
                ea = exp_a.pop_front();
                check("write_addr_a", addr_a, ea.addr);
                check("write_data_a", wdata_a, ea.data);
            end
        end
    end

    // Monitor for the 4-word instance's write port.
    always @(negedge clk) begin
        if (we_b) begin
            check("ready_low_in_write_b", 32'(ready_b), 0);
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write_b actual addr=0x%0h data=0x%0h required=no write", addr_b, wdata_b);
            end else begin
                eb = exp_b.pop_front();
                check("write_addr_b", addr_b, eb.addr);
                check("write_data_b", wdata_b, eb.data);
            end
        end
    end

    // Present a request and wait (bounded) for the selected instance to take it.
    // Returns just after the transfer edge, i.e. inside the WRITE cycle.
    task automatic try_op(input bit sel, input int k, input int s, input int t, input int d,
                          input int f, input int im, input int l, output bit accepted);
        kind     = 3'(k);
        rs       = 5'(s);
        rt       = 5'(t);
        rd       = 5'(d);
        funct    = 6'(f);
        imm      = 16'(im);
        last     = 1'(l);
        valid    = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sel ? ready_b : ready_a) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
    endtask

    task automatic op(input bit sel, input int k, input int s, input int t, input int d,
                      input int f, input int im, input int l,
                      input logic [31:0] xaddr, input logic [31:0] xdata);
        bit a;
        wr_t w;
        w.addr = xaddr;
        w.data = xdata;
        if (sel) exp_b.push_back(w);
        else     exp_a.push_back(w);
        try_op(sel, k, s, t, d, f, im, l, a);
        check("op_accepted", 32'(a), 1);
    endtask

    task automatic start_session(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input bit sel);
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? (done_b | err_b) : (done_a | err_a)) begin
                ended = 1'b1;
                break;
            end
        end
        check("session_end_seen", 32'(ended), 1);
    endtask

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; valid = 1'b0; last = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_a), 0);
        check("rst_we", 32'(we_a), 0);
        check("rst_count", 32'(count_a), 0);
        check("rst_flags", {29'd0, done_a, err_a, 1'b0} | 32'(code_a), 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single addi, last.
        start_session(0);
        op(0, 1, 1, 2, 0, 0, 16'h0005, 1, 32'h0, 32'h24220005);
        wait_end(0);
        check("t1_done", 32'(done_a), 1);
        check("t1_err", 32'(err_a), 0);
        check("t1_count", 32'(count_a), 1);

        // Five-op program covering every legal kind.
        start_session(0);
        op(0, 0, 1, 2, 3, 6'h20, 0,       0, 32'h00, 32'h00221820);
        op(0, 2, 0, 4, 0, 0,     16'h0008, 0, 32'h04, 32'hB0040008);
        op(0, 3, 0, 4, 0, 0,     16'h000C, 0, 32'h08, 32'h9004000C);
        op(0, 4, 1, 2, 0, 0,     16'hFFFF, 0, 32'h0C, 32'h1822FFFF);
        op(0, 5, 1, 2, 0, 0,     16'h0002, 1, 32'h10, 32'h14220002);
        wait_end(0);
        check("t2_done", 32'(done_a), 1);
        check("t2_count", 32'(count_a), 5);

        // Illegal kind after two legal ops, then restart.
        start_session(0);
        op(0, 1, 1, 2, 0, 0, 16'h0005, 0, 32'h0, 32'h24220005);
        op(0, 2, 0, 4, 0, 0, 16'h0008, 0, 32'h4, 32'hB0040008);
        try_op(0, 6, 1, 1, 1, 0, 0, 0, acc);
        check("t3_illegal_accepted", 32'(acc), 1);
        wait_end(0);
        check("t3_err", 32'(err_a), 1);
        check("t3_code", 32'(code_a), 1);
        check("t3_done", 32'(done_a), 0);
        check("t3_count", 32'(count_a), 2);
        check("t3_ready_in_error", 32'(ready_a), 0);
        start_session(0);
        check("t3_restart_clears_err", 32'(err_a), 0);
        op(0, 1, 1, 2, 0, 0, 16'h0005, 1, 32'h0, 32'h24220005);
        wait_end(0);
        check("t3_restart_count", 32'(count_a), 1);

        // start_i during an active session is ignored.
        start_session(0);
        op(0, 0, 1, 2, 3, 6'h20, 0, 0, 32'h0, 32'h00221820);
        start_a = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        check("t4_count_kept", 32'(count_a), 1);
        check("t4_still_accept", 32'(ready_a), 1);
        op(0, 2, 0, 4, 0, 0, 16'h0008, 1, 32'h4, 32'hB0040008);
        wait_end(0);
        check("t4_count", 32'(count_a), 2);

        // Overflow on the 4-word instance.
        start_session(1);
        for (int i = 0; i < 4; i++) begin
            op(1, 1, 1, 2, 0, 0, i, 0, 32'(i * 4), 32'h24220000 | 32'(i));
        end
        try_op(1, 1, 1, 2, 0, 0, 4, 0, acc);
        check("t5_fifth_not_accepted", 32'(acc), 0);
        check("t5_err", 32'(err_b), 1);
        check("t5_code", 32'(code_b), 2);
        check("t5_count", 32'(count_b), 4);
        check("t5_done", 32'(done_b), 0);

        // Reset landing on a WRITE cycle.
        start_session(0);
        try_op(0, 1, 3, 3, 0, 0, 16'h1234, 0, acc);
        check("t6_accepted", 32'(acc), 1);
        rst   = 1'b0;
        valid = 1'b1;
        kind  = 3'd1;
        @(posedge clk);
        #1;
        check("t6_we_after_rst", 32'(we_a), 0);
        check("t6_count_after_rst", 32'(count_a), 0);
        check("t6_addr_after_rst", addr_a, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_ready_idle", 32'(ready_a), 0);
        end
        valid = 1'b0;

        repeat (2) @(posedge clk);
        check("pending_writes_a", 32'(exp_a.size()), 0);
        check("pending_writes_b", 32'(exp_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
